// File: rtl/memory_stage.sv
// Memory stage: data-cache access control, load-data hold under freeze,
// and the LL/SC link register with snoop invalidation.
module memory_stage (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        dREN_in,
   input  logic        dWEN_in,
   input  logic        ll_in,
   input  logic        sc_in,
   input  logic [31:0] addr_in,
   input  logic [31:0] store_in,
   input  logic [31:0] port_o_in,
   input  logic [4:0]  wsel_in,
   input  logic        WEN_in,
   input  logic        halt_in,
   input  logic        freeze_in,
   input  logic        dhit,
   input  logic [31:0] dmemload,
   input  logic        inv_valid,
   input  logic [31:0] inv_addr,
   output logic        dmemREN,
   output logic        dmemWEN,
   output logic [31:0] dmemaddr,
   output logic [31:0] dmemstore,
   output logic        mem_stall,
   output logic [31:0] dmemload_out,
   output logic [31:0] port_o_out,
   output logic [4:0]  wsel_out,
   output logic        WEN_out,
   output logic        halt_out
);

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } state_t;

   state_t state;
   state_t nxt;

   word_t ldata;
   word_t link_addr;
   logic  link_valid;
   logic  sc_res;

   logic busy;
   logic is_sc;
   logic link_match;
   logic sc_fail;
   logic mem_op;
   logic hit_op;
   logic ll_done;
   logic st_done;
   logic inv_hit;
   logic inv_ll;
   logic unused_bits;

   assign busy       = (state != DONE);
   assign is_sc      = sc_in & dWEN_in;
   assign link_match = (link_addr[31:2] == addr_in[31:2]);
   assign sc_fail    = sc_in & ~(link_valid & link_match);
   assign mem_op     = dREN_in | (dWEN_in & ~sc_fail);
   assign hit_op     = busy & mem_op & dhit;

   assign ll_done = busy & dREN_in & ll_in & dhit;
   assign st_done = hit_op & dWEN_in & link_match;
   assign inv_hit = inv_valid
                  & (inv_addr[31:2] == link_addr[31:2]);
   assign inv_ll  = inv_valid
                  & (inv_addr[31:2] == addr_in[31:2]);

   assign unused_bits = ^{inv_addr[1:0], link_addr[1:0]};

   assign dmemaddr  = addr_in;
   assign dmemstore = store_in;
   assign wsel_out  = wsel_in;
   assign WEN_out   = WEN_in & ~mem_stall;
   assign halt_out  = halt_in & ~mem_stall;

   always_comb begin
      nxt          = state;
      dmemREN      = 1'b0;
      dmemWEN      = 1'b0;
      mem_stall    = 1'b0;
      dmemload_out = dmemload;
      port_o_out   = port_o_in;
      unique case (state)
         IDLE, WAIT: begin
            dmemREN   = dREN_in & nRST;
            dmemWEN   = dWEN_in & ~sc_fail & nRST;
            mem_stall = mem_op & ~dhit & nRST;
            if (is_sc) begin
               port_o_out = {31'd0, ~sc_fail};
            end
            if (mem_op & dhit) begin
               nxt = freeze_in ? DONE : IDLE;
            end else if (mem_op) begin
               nxt = WAIT;
            end else if ((state == WAIT) & ~dhit) begin
               nxt = WAIT;
            end else begin
               nxt = IDLE;
            end
         end
         DONE: begin
            // Access already finished; replay the captured results only.
            dmemload_out = ldata;
            if (is_sc) begin
               port_o_out = {31'd0, sc_res};
            end
            nxt = freeze_in ? DONE : IDLE;
         end
         default: begin
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ldata  <= '0;
         sc_res <= 1'b0;
      end else if (hit_op & freeze_in) begin
         ldata  <= dmemload;
         sc_res <= ~sc_fail;
      end
   end

   // A snoop to the word being linked this cycle beats the LL.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else if (ll_done) begin
         link_valid <= ~inv_ll;
         link_addr  <= addr_in;
      end else if (inv_hit | st_done) begin
         link_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: vector table, corner sequences,
// and random traffic against a behavioural model.
module tb_memory_stage;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        dREN_in, dWEN_in, ll_in, sc_in;
   logic [31:0] addr_in, store_in, port_o_in;
   logic [4:0]  wsel_in;
   logic        WEN_in, halt_in, freeze_in, dhit;
   logic [31:0] dmemload;
   logic        inv_valid;
   logic [31:0] inv_addr;
   logic        dmemREN, dmemWEN, mem_stall;
   logic [31:0] dmemaddr, dmemstore, dmemload_out, port_o_out;
   logic [4:0]  wsel_out;
   logic        WEN_out, halt_out;

   int errors = 0;
   int checks = 0;

   memory_stage dut (
      .CLK(CLK), .nRST(nRST),
      .dREN_in(dREN_in), .dWEN_in(dWEN_in),
      .ll_in(ll_in), .sc_in(sc_in),
      .addr_in(addr_in), .store_in(store_in),
      .port_o_in(port_o_in), .wsel_in(wsel_in),
      .WEN_in(WEN_in), .halt_in(halt_in),
      .freeze_in(freeze_in), .dhit(dhit),
      .dmemload(dmemload),
      .inv_valid(inv_valid), .inv_addr(inv_addr),
      .dmemREN(dmemREN), .dmemWEN(dmemWEN),
      .dmemaddr(dmemaddr), .dmemstore(dmemstore),
      .mem_stall(mem_stall),
      .dmemload_out(dmemload_out),
      .port_o_out(port_o_out), .wsel_out(wsel_out),
      .WEN_out(WEN_out), .halt_out(halt_out)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        ren, wen, ll, sc, frz, dh;
      logic [31:0] addr, ld, po;
      logic        e_ren, e_wen, e_stall, e_weno;
      logic [31:0] e_ld, e_po;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t",
                  nm, got, exp, $time);
      end
   endtask

   task automatic drv(input logic r, w, l, s, f, h,
                      input logic [31:0] a, d, p);
      dREN_in = r; dWEN_in = w; ll_in = l; sc_in = s;
      freeze_in = f; dhit = h; addr_in = a;
      dmemload = d; port_o_in = p; inv_valid = 1'b0;
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // behavioural model
   logic        m_held, m_hsc, m_lv;
   logic [31:0] m_hd, m_la;
   logic        r, w, l, s, f, h, iv, scf, op;
   logic [31:0] a, d, p, ia;
   logic [4:0]  ws;
   logic        we, hl;
   logic [31:0] pool [4];

   initial begin
      pool[0] = 32'h200; pool[1] = 32'h204;
      pool[2] = 32'h206; pool[3] = 32'h300;

      tv.push_back('{1,0,0,0,0,0, 32'h100, 32'h0, 32'h11,
                     1,0,1,0, 32'h0, 32'h11});
      tv.push_back('{1,0,0,0,0,0, 32'h100, 32'h0, 32'h11,
                     1,0,1,0, 32'h0, 32'h11});
      tv.push_back('{1,0,0,0,0,0, 32'h100, 32'h0, 32'h11,
                     1,0,1,0, 32'h0, 32'h11});
      tv.push_back('{1,0,0,0,0,1, 32'h100, 32'hDEADBEEF, 32'h11,
                     1,0,0,1, 32'hDEADBEEF, 32'h11});
      tv.push_back('{0,1,0,0,1,1, 32'h300, 32'h0, 32'h22,
                     0,1,0,1, 32'h0, 32'h22});
      tv.push_back('{0,1,0,0,1,1, 32'h300, 32'h0, 32'h22,
                     0,0,0,1, 32'h0, 32'h22});
      tv.push_back('{0,1,0,0,0,1, 32'h300, 32'h0, 32'h22,
                     0,0,0,1, 32'h0, 32'h22});
      tv.push_back('{0,0,0,0,0,0, 32'h0, 32'h0, 32'h33,
                     0,0,0,1, 32'h0, 32'h33});
      tv.push_back('{1,0,0,0,1,1, 32'h100, 32'hCAFEF00D, 32'h44,
                     1,0,0,1, 32'hCAFEF00D, 32'h44});
      tv.push_back('{1,0,0,0,1,0, 32'h100, 32'h0, 32'h44,
                     0,0,0,1, 32'hCAFEF00D, 32'h44});
      tv.push_back('{1,0,0,0,0,0, 32'h100, 32'h0, 32'h44,
                     0,0,0,1, 32'hCAFEF00D, 32'h44});
      tv.push_back('{0,0,0,0,0,0, 32'h0, 32'h12345678, 32'h33,
                     0,0,0,1, 32'h12345678, 32'h33});
      tv.push_back('{1,0,1,0,0,1, 32'h200, 32'hABCD, 32'h55,
                     1,0,0,1, 32'hABCD, 32'h55});
      tv.push_back('{0,1,0,1,0,1, 32'h200, 32'h0, 32'h66,
                     0,1,0,1, 32'h0, 32'h1});
      tv.push_back('{0,1,0,1,0,1, 32'h200, 32'h0, 32'h66,
                     0,0,0,1, 32'h0, 32'h0});
      tv.push_back('{1,0,1,0,0,1, 32'h204, 32'h0, 32'h55,
                     1,0,0,1, 32'h0, 32'h55});
      tv.push_back('{0,1,0,1,0,0, 32'h204, 32'h0, 32'h66,
                     0,1,1,0, 32'h0, 32'h1});
      tv.push_back('{0,1,0,1,0,1, 32'h204, 32'h0, 32'h66,
                     0,1,0,1, 32'h0, 32'h1});

      // reset state, with a load already presented
      nRST = 1'b0;
      store_in = 32'h55; wsel_in = 5'd3;
      WEN_in = 1'b1; halt_in = 1'b1; inv_addr = '0;
      drv(1,1,0,0,0,0, 32'h100, 0, 0);
      #2;
      chk("rst_ren", {31'd0, dmemREN}, 0);
      chk("rst_wen", {31'd0, dmemWEN}, 0);
      chk("rst_stall", {31'd0, mem_stall}, 0);
      step();
      drv(0,0,0,0,0,0, 0, 0, 0);
      nRST = 1'b1;
      step();

      for (int i = 0; i < tv.size(); i++) begin
         drv(tv[i].ren, tv[i].wen, tv[i].ll, tv[i].sc,
             tv[i].frz, tv[i].dh,
             tv[i].addr, tv[i].ld, tv[i].po);
         @(negedge CLK);
         chk($sformatf("v%0d_ren", i),
             {31'd0, dmemREN}, {31'd0, tv[i].e_ren});
         chk($sformatf("v%0d_wen", i),
             {31'd0, dmemWEN}, {31'd0, tv[i].e_wen});
         chk($sformatf("v%0d_stall", i),
             {31'd0, mem_stall}, {31'd0, tv[i].e_stall});
         chk($sformatf("v%0d_weno", i),
             {31'd0, WEN_out}, {31'd0, tv[i].e_weno});
         chk($sformatf("v%0d_halt", i),
             {31'd0, halt_out}, {31'd0, tv[i].e_weno});
         chk($sformatf("v%0d_ld", i), dmemload_out, tv[i].e_ld);
         chk($sformatf("v%0d_po", i), port_o_out, tv[i].e_po);
         step();
      end

      // snoop to other word keeps link, snoop to linked word clears it
      drv(1,0,1,0,0,1, 32'h200, 0, 0);
      step();
      drv(0,0,0,0,0,0, 0, 0, 0);
      inv_valid = 1'b1; inv_addr = 32'h204;
      step();
      drv(0,1,0,1,0,1, 32'h200, 0, 32'h9);
      @(negedge CLK);
      chk("inv_other_po", port_o_out, 1);
      chk("inv_other_wen", {31'd0, dmemWEN}, 1);
      step();
      drv(1,0,1,0,0,1, 32'h200, 0, 0);
      step();
      drv(0,0,0,0,0,0, 0, 0, 0);
      inv_valid = 1'b1; inv_addr = 32'h200;
      step();
      drv(0,1,0,1,0,0, 32'h200, 0, 32'h9);
      @(negedge CLK);
      chk("inv_same_po", port_o_out, 0);
      chk("inv_same_wen", {31'd0, dmemWEN}, 0);
      chk("inv_same_stall", {31'd0, mem_stall}, 0);
      step();

      // LL completing together with a snoop of the same word
      drv(1,0,1,0,0,1, 32'h200, 0, 0);
      inv_valid = 1'b1; inv_addr = 32'h200;
      step();
      drv(0,1,0,1,0,1, 32'h200, 0, 32'h9);
      @(negedge CLK);
      chk("ll_inv_po", port_o_out, 0);
      chk("ll_inv_wen", {31'd0, dmemWEN}, 0);
      step();

      // SC success held across freeze
      drv(1,0,1,0,0,1, 32'h300, 0, 0);
      step();
      drv(0,1,0,1,1,1, 32'h300, 0, 32'h9);
      @(negedge CLK);
      chk("scf_po0", port_o_out, 1);
      chk("scf_wen0", {31'd0, dmemWEN}, 1);
      step();
      @(negedge CLK);
      chk("scf_po1", port_o_out, 1);
      chk("scf_wen1", {31'd0, dmemWEN}, 0);
      step();
      freeze_in = 1'b0;
      @(negedge CLK);
      chk("scf_po2", port_o_out, 1);
      step();

      // reset during WAIT
      drv(1,0,0,0,0,0, 32'h100, 0, 0);
      step();
      @(negedge CLK);
      chk("wait_stall", {31'd0, mem_stall}, 1);
      @(posedge CLK);
      #2 nRST = 1'b0;
      #1;
      chk("rstw_ren", {31'd0, dmemREN}, 0);
      chk("rstw_stall", {31'd0, mem_stall}, 0);
      step();
      nRST = 1'b1;
      @(negedge CLK);
      chk("rstw_ren_after", {31'd0, dmemREN}, 1);
      step();

      // reset during DONE also drops the link
      drv(1,0,1,0,0,1, 32'h400, 0, 0);
      step();
      drv(1,0,0,0,1,1, 32'h100, 32'h77, 0);
      step();
      dhit = 1'b0;
      @(negedge CLK);
      chk("done_ren", {31'd0, dmemREN}, 0);
      chk("done_ld", dmemload_out, 32'h77);
      @(posedge CLK);
      #2 nRST = 1'b0;
      step();
      nRST = 1'b1;
      @(negedge CLK);
      chk("rstd_ren", {31'd0, dmemREN}, 1);
      chk("rstd_stall", {31'd0, mem_stall}, 1);
      step();
      drv(0,1,0,1,0,1, 32'h400, 0, 32'h9);
      @(negedge CLK);
      chk("rstd_sc_po", port_o_out, 0);
      step();

      // random traffic against the model
      nRST = 1'b0;
      drv(0,0,0,0,0,0, 0, 0, 0);
      step();
      nRST = 1'b1;
      m_held = 0; m_hsc = 0; m_lv = 0; m_hd = 0; m_la = 0;
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom % 3) == 0;
         w  = !r && (($urandom % 3) == 0);
         l  = r && $urandom_range(0, 1);
         s  = w && $urandom_range(0, 1);
         f  = ($urandom % 4) == 0;
         h  = $urandom_range(0, 1);
         iv = ($urandom % 5) == 0;
         a  = pool[$urandom % 4];
         ia = pool[$urandom % 4];
         d  = $urandom;
         p  = $urandom;
         ws = 5'($urandom);
         we = $urandom_range(0, 1);
         hl = $urandom_range(0, 1);
         drv(r, w, l, s, f, h, a, d, p);
         inv_valid = iv; inv_addr = ia;
         wsel_in = ws; WEN_in = we; halt_in = hl;
         store_in = ~p;
         @(negedge CLK);
         scf = s && !(m_lv && m_la[31:2] == a[31:2]);
         op  = r || (w && !scf);
         chk("r_ren", {31'd0, dmemREN}, {31'd0, !m_held && r});
         chk("r_wen", {31'd0, dmemWEN},
             {31'd0, !m_held && w && !scf});
         chk("r_stall", {31'd0, mem_stall},
             {31'd0, !m_held && op && !h});
         chk("r_weno", {31'd0, WEN_out},
             {31'd0, we && !(!m_held && op && !h)});
         chk("r_halt", {31'd0, halt_out},
             {31'd0, hl && !(!m_held && op && !h)});
         chk("r_ld", dmemload_out, m_held ? m_hd : d);
         chk("r_po", port_o_out,
             (s && w) ? {31'd0, m_held ? m_hsc : !scf} : p);
         chk("r_addr", dmemaddr, a);
         chk("r_store", dmemstore, ~p);
         chk("r_wsel", {27'd0, wsel_out}, {27'd0, ws});
         if (!m_held && r && l && h) begin
            m_la = a;
            m_lv = !(iv && ia[31:2] == a[31:2]);
         end else if ((iv && ia[31:2] == m_la[31:2]) ||
                      (!m_held && w && !scf && h &&
                       a[31:2] == m_la[31:2])) begin
            m_lv = 0;
         end
         if (!m_held) begin
            if (op && h && f) begin
               m_held = 1; m_hd = d; m_hsc = !scf;
            end
         end else if (!f) begin
            m_held = 0;
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
